// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sha3_pkg
// Description : Shared types and helpers for the SHA3 digest serializer:
//               variant id, Keccak state layout, digest sizing, lane byte
//               swap and digest extraction from the final state.
// Revision    : 1.0 - initial release
// ============================================================================
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_id_t;

  typedef logic [0:4][0:4][63:0] keccak_state_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  localparam int unsigned DIGEST_LANES_MAX = 8;
  localparam int unsigned DIGEST_BITS_MAX  = DIGEST_LANES_MAX * 64;

  // Digest length in bits for each variant.
  function automatic int unsigned digest_bits(sha3_id_t id);
    int unsigned bits;
    case (id)
      SHA3_224: bits = 224;
      SHA3_256: bits = 256;
      SHA3_384: bits = 384;
      default:  bits = 512;
    endcase
    return bits;
  endfunction

  // Reverse byte order of a lane: raw byte0 (LSB) becomes the MSB.
  function automatic logic [63:0] bswap64(logic [63:0] lane);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = lane[56-8*i +: 8];
    end
    return r;
  endfunction

  // Lanes 0..7 (lane k = st[k%5][k/5]) byte-swapped and packed MSB-first.
  function automatic logic [DIGEST_BITS_MAX-1:0] extract_digest(keccak_state_t st);
    logic [DIGEST_BITS_MAX-1:0] d;
    d = '0;
    for (int k = 0; k < int'(DIGEST_LANES_MAX); k++) begin
      d[int'(DIGEST_BITS_MAX)-1-64*k -: 64] = bswap64(st[k%5][k/5]);
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha3_digest_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sha3_digest_serializer
// Description : Captures the final Keccak state, extracts the byte-swapped
//               digest lanes for the selected SHA3 variant and streams the
//               digest as WIDTH-bit beats (valid/ready/last), MSB first.
//               Optional macro DIGEST_ZEROIZE_EN clears the digest buffer
//               when the last beat transfers and forces m_data to zero
//               whenever m_valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_digest_serializer
  import sha3_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LANE_W = 64
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_id,
  input  keccak_state_t    s_state,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int unsigned BUF_W = DIGEST_LANES_MAX * LANE_W;
  localparam int unsigned CNT_W = $clog2(BUF_W / WIDTH);

  // Index of the final beat for a variant; the counter stops here.
  function automatic logic [CNT_W-1:0] last_beat(sha3_id_t id);
    return CNT_W'(digest_bits(id) / WIDTH - 1);
  endfunction

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sha3_id_t         id_q, id_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;

  logic             w_take;
  logic             w_xfer;
  logic [BUF_W-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;

  assign w_take = s_valid && s_ready_q;
  assign w_xfer = m_valid_q && m_ready;

  // Next-state logic: capture in IDLE, advance beat counter on each transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (w_take) begin
          state_d = ST_SEND;
          buf_d   = extract_digest(s_state);
          id_d    = sha3_id_t'(s_id);
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (cnt_q == last_beat(id_q)) begin
            // Counter parks on the last beat so the idle output keeps that word.
            state_d = ST_IDLE;
`ifdef DIGEST_ZEROIZE_EN
            buf_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d == ST_IDLE);
    m_valid_d = (state_d == ST_SEND);
    m_last_d  = (state_d == ST_SEND) && (cnt_d == last_beat(id_d));
  end

  // State, counter, buffer and handshake outputs registered with sync reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      id_q      <= SHA3_224;
      buf_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      buf_q     <= buf_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  // Current beat: the word at bit offset cnt*WIDTH from the digest MSB.
  always_comb begin
    w_shifted = buf_q << (32'(cnt_q) * WIDTH);
    w_word    = w_shifted[BUF_W-1 -: WIDTH];
  end

`ifdef DIGEST_ZEROIZE_EN
  assign m_data = m_valid_q ? w_word : '0;
`else
  assign m_data = w_word;
`endif
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule
`default_nettype wire
